// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response and data-RAM signal bundle for mem_access_unit
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic [2:0]              req_op;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;

    logic                    resp_valid;
    logic [DATA_WIDTH-1:0]   resp_rdata;
    logic                    resp_adel;
    logic                    resp_ades;
    logic [ADDR_WIDTH-1:0]   resp_badvaddr;

    logic                    ram_en;
    logic [DATA_WIDTH/8-1:0] ram_write_en;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [DATA_WIDTH-1:0]   ram_write_data;
    logic [DATA_WIDTH-1:0]   ram_read_data;

    // The access unit: takes requests from the MEM stage, initiates RAM accesses
    modport master (
        input  req_valid, req_op, req_addr, req_wdata, ram_read_data,
        output req_ready, resp_valid, resp_rdata, resp_adel, resp_ades, resp_badvaddr,
               ram_en, ram_write_en, ram_addr, ram_write_data
    );

    // The environment: MEM stage issuing requests and the RAM answering reads
    modport slave (
        output req_valid, req_op, req_addr, req_wdata, ram_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_adel, resp_ades, resp_badvaddr,
               ram_en, ram_write_en, ram_addr, ram_write_data
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store initiator for the data RAM with lane steering and alignment checks
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    mem_access_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                  state_q;
    logic [2:0]              op_q;
    logic [1:0]              off_q;
    logic [ADDR_WIDTH-1:0]   ram_addr_q;
    logic [DATA_WIDTH-1:0]   ram_wdata_q;
    logic [3:0]              we_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    adel_q;
    logic                    ades_q;
    logic [ADDR_WIDTH-1:0]   badvaddr_q;

    logic [3:0]              we_d;
    logic [DATA_WIDTH-1:0]   wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_d;
    logic                    mis_load;
    logic                    mis_store;
    logic                    req_ready;
    logic                    accept;
    logic [1:0]              off;
    logic [DATA_WIDTH-1:0]   rd_shift;
    logic [7:0]              lane_b;
    logic [15:0]             lane_h;

    assign off       = bus.req_addr[1:0];
    assign req_ready = (state_q == IDLE) && !flush && !rst;
    assign accept    = bus.req_valid && req_ready;

    // Alignment check and store lane steering for the request being offered
    always_comb begin
        mis_load  = ((bus.req_op == 3'd2 || bus.req_op == 3'd3) && off[0]) ||
                    (bus.req_op == 3'd4 && off != 2'b00);
        mis_store = (bus.req_op == 3'd6 && off[0]) ||
                    (bus.req_op == 3'd7 && off != 2'b00);
        we_d      = 4'b0000;
        wdata_d   = ram_wdata_q;
        case (bus.req_op)
            3'd5: begin
                we_d    = 4'b0001 << off;
                wdata_d = {4{bus.req_wdata[7:0]}};
            end
            3'd6: begin
                we_d    = off[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{bus.req_wdata[15:0]}};
            end
            3'd7: begin
                we_d    = 4'b1111;
                wdata_d = bus.req_wdata;
            end
            default: ;
        endcase
    end

    // Pick the addressed byte/half out of the RAM word and extend it
    always_comb begin
        rd_shift = bus.ram_read_data >> {off_q, 3'b000};
        lane_b   = rd_shift[7:0];
        lane_h   = off_q[1] ? bus.ram_read_data[31:16] : bus.ram_read_data[15:0];
        case (op_q)
            3'd0:    rdata_d = {{24{lane_b[7]}}, lane_b};
            3'd1:    rdata_d = {24'd0, lane_b};
            3'd2:    rdata_d = {{16{lane_h[15]}}, lane_h};
            3'd3:    rdata_d = {16'd0, lane_h};
            3'd4:    rdata_d = bus.ram_read_data;
            default: rdata_d = '0;
        endcase
    end

    // Request FSM: latch on handshake, one RAM cycle, one response cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= 3'd0;
            off_q       <= 2'b00;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            we_q        <= 4'b0000;
            rdata_q     <= '0;
            adel_q      <= 1'b0;
            ades_q      <= 1'b0;
            badvaddr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q    <= bus.req_op;
                        off_q   <= off;
                        rdata_q <= '0;
                        adel_q  <= mis_load;
                        ades_q  <= mis_store;
                        if (mis_load || mis_store) begin
                            // Misaligned: skip the RAM entirely, keep its lines as they were
                            badvaddr_q <= bus.req_addr;
                            state_q    <= RESP;
                        end else begin
                            badvaddr_q  <= '0;
                            ram_addr_q  <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                            ram_wdata_q <= wdata_d;
                            we_q        <= we_d;
                            state_q     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    rdata_q <= rdata_d;
                    state_q <= flush ? IDLE : RESP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Flush and reset gate the RAM strobes and response in the same cycle
    assign bus.req_ready      = req_ready;
    assign bus.ram_en         = (state_q == ACCESS) && !flush && !rst;
    assign bus.ram_write_en   = bus.ram_en ? we_q : 4'b0000;
    assign bus.ram_addr       = rst ? '0 : ram_addr_q;
    assign bus.ram_write_data = rst ? '0 : ram_wdata_q;
    assign bus.resp_valid     = (state_q == RESP) && !flush && !rst;
    assign bus.resp_rdata     = bus.resp_valid ? rdata_q : '0;
    assign bus.resp_adel      = bus.resp_valid && adel_q;
    assign bus.resp_ades      = bus.resp_valid && ades_q;
    assign bus.resp_badvaddr  = bus.resp_valid ? badvaddr_q : '0;
endmodule
